// File: rtl/axi_mm_burst_pkg.sv
// Shared types and helpers for the AXI4 memory-mapped burst generator/checker pair.
package axi_mm_burst_pkg;

  // Controller states. IDLE encodes as zero so the reset value of the debug state reads as 0.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // AXSIZE encoding for a bus of the given width in bits.
  function automatic logic [2:0] size_from_width(input int width);
    return 3'($clog2(width / 8));
  endfunction

endpackage

// File: rtl/axi_mm_burst_len_calc.sv
// Burst length selection: the smallest of the configured maximum, the beats left
// in the pass, and the beats left before the next 4 KB boundary.
module axi_mm_burst_len_calc #(
  parameter int SIZE          = 2,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [11:0] addr_lo,
  input  logic [15:0] remaining,
  output logic [8:0]  len
);

  logic [12:0] to_4k;
  logic [16:0] cand;

  // Take the minimum of the three limits; the address is beat aligned so the shift is exact.
  always_comb begin
    to_4k = (13'h1000 - {1'b0, addr_lo}) >> SIZE;
    cand  = 17'(MAX_BURST_LEN);
    if ({1'b0, remaining} < cand) cand = {1'b0, remaining};
    if ({4'b0, to_4k} < cand)     cand = {4'b0, to_4k};
    len = cand[8:0];
  end

endmodule

// File: rtl/data_chk_axi_mm_burst.sv
// AXI4 read-only burst master that reads a region back, optionally several passes,
// and checks each beat against the incrementing byte pattern of the generator.
//
// Handshakes: a transfer happens on a rising ap_clk edge where valid and ready are
// both high. ARVALID, once raised, stays high with ARADDR/ARLEN stable until ARREADY.
// RREADY is high for the whole DATA state; a burst ends on the beat count, and RLAST
// is only checked, never used to terminate.
module data_chk_axi_mm_burst
  import axi_mm_burst_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BURST_LEN  = 16
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [15:0]               BYTES,
  input  logic [15:0]               REPEAT,
  input  logic                      START,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [31:0]               ERR_CNT,
  output logic [AXI_ADDR_WIDTH-1:0] FIRST_ERR_ADDR,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output state_t                    dbg_state
);

  localparam int         BPB  = AXI_DATA_WIDTH / 8;
  localparam logic [2:0] SIZE = size_from_width(AXI_DATA_WIDTH);

  state_t                    state, state_nx;
  logic [AXI_ADDR_WIDTH-1:0] base_r, addr_r;
  logic [15:0]               beats_r, pass_left, passes_left, offset_r, beats_in;
  logic [8:0]                burst_len, beat_cnt, len_calc_out;
  logic                      empty_r, beat_fire, last_beat, mism, beat_err;

  assign beats_in = BYTES >> SIZE;

  axi_mm_burst_len_calc #(
    .SIZE          (int'(SIZE)),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_len_calc (
    .addr_lo   (addr_r[11:0]),
    .remaining (pass_left),
    .len       (len_calc_out)
  );

  assign m_axi_arsize  = SIZE;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = (state == ST_ADDR) && !empty_r;
  assign m_axi_araddr  = m_axi_arvalid ? addr_r : '0;
  assign m_axi_arlen   = m_axi_arvalid ? 8'(len_calc_out - 9'd1) : 8'd0;
  assign m_axi_rready  = (state == ST_DATA);
  assign BUSY          = (state != ST_IDLE);
  assign DONE          = (state == ST_DONE);
  assign dbg_state     = state;

  assign beat_fire = (state == ST_DATA) && m_axi_rvalid;
  assign last_beat = (beat_cnt == burst_len - 9'd1);

  // Compare every byte lane with its pattern byte and fold in response/RLAST faults.
  always_comb begin
    mism = 1'b0;
    for (int i = 0; i < BPB; i++) begin
      if (m_axi_rdata[8*i +: 8] != 8'(offset_r + 16'(i))) mism = 1'b1;
    end
    beat_err = mism || (m_axi_rresp != RESP_OKAY) || (m_axi_rlast != last_beat);
  end

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= ST_IDLE;
    else           state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (START) state_nx = ST_ADDR;
      ST_ADDR: begin
        if (empty_r)            state_nx = ST_DONE;
        else if (m_axi_arready) state_nx = ST_DATA;
      end
      ST_DATA: if (beat_fire && last_beat) state_nx = ST_NEXT;
      ST_NEXT: begin
        if ((pass_left != 16'd0) || (passes_left > 16'd1)) state_nx = ST_ADDR;
        else                                               state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath: configuration latch, per-beat address/offset walk, pass restart, error capture.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      base_r         <= '0;
      addr_r         <= '0;
      beats_r        <= '0;
      pass_left      <= '0;
      passes_left    <= '0;
      offset_r       <= '0;
      empty_r        <= 1'b0;
      burst_len      <= '0;
      beat_cnt       <= '0;
      ERR_CNT        <= '0;
      FIRST_ERR_ADDR <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            base_r         <= BASE_ADDR;
            addr_r         <= BASE_ADDR;
            beats_r        <= beats_in;
            pass_left      <= beats_in;
            passes_left    <= REPEAT;
            offset_r       <= '0;
            empty_r        <= (beats_in == 16'd0) || (REPEAT == 16'd0);
            ERR_CNT        <= '0;
            FIRST_ERR_ADDR <= '0;
          end
        end
        ST_ADDR: begin
          if (m_axi_arvalid && m_axi_arready) begin
            burst_len <= len_calc_out;
            beat_cnt  <= '0;
          end
        end
        ST_DATA: begin
          if (beat_fire) begin
            addr_r    <= addr_r + AXI_ADDR_WIDTH'(BPB);
            offset_r  <= offset_r + 16'(BPB);
            pass_left <= pass_left - 16'd1;
            beat_cnt  <= beat_cnt + 9'd1;
            if (beat_err) begin
              if (ERR_CNT != '1)      ERR_CNT        <= ERR_CNT + 32'd1;
              if (ERR_CNT == 32'd0)   FIRST_ERR_ADDR <= addr_r;
            end
          end
        end
        ST_NEXT: begin
          if ((pass_left == 16'd0) && (passes_left > 16'd1)) begin
            addr_r      <= base_r;
            offset_r    <= '0;
            pass_left   <= beats_r;
            passes_left <= passes_left - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_chk_axi_mm_burst.sv
// Bench for data_chk_axi_mm_burst: a randomly stalling AXI read slave serving the
// generator pattern with injectable faults, and an address-channel scoreboard.
module tb_data_chk_axi_mm_burst;
  import axi_mm_burst_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BPB = DW / 8;

  // ---------------- clock / reset ----------------
  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic [AW-1:0] BASE_ADDR;
  logic [15:0]   BYTES, REPEAT;
  logic          START;
  logic          BUSY, DONE;
  logic [31:0]   ERR_CNT;
  logic [AW-1:0] FIRST_ERR_ADDR;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  state_t        dbg_state;

  data_chk_axi_mm_burst #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .MAX_BURST_LEN(16)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .BASE_ADDR(BASE_ADDR), .BYTES(BYTES), .REPEAT(REPEAT), .START(START),
    .BUSY(BUSY), .DONE(DONE), .ERR_CNT(ERR_CNT), .FIRST_ERR_ADDR(FIRST_ERR_ADDR),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [AW+8-1:0] exp_q[$];   // expected {araddr, arlen} per burst
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Fault knobs for the slave, set by the tests while the DUT is idle.
  int            corrupt_off      = -1;  // pattern offset of a flipped byte
  int            bad_resp_beat    = -1;  // beat index (within a run) returning SLVERR
  int            drop_rlast_burst = -1;  // burst index (within a run) missing RLAST
  logic [AW-1:0] cur_base         = '0;

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    logic [15:0]   off;
    d = '0;
    for (int i = 0; i < BPB; i++) begin
      off = 16'(a - cur_base) + 16'(i);
      d[8*i +: 8] = (int'(off) == corrupt_off) ? ~off[7:0] : off[7:0];
    end
    return d;
  endfunction

  // ---------------- AXI read slave + AR monitor (driven on negedge) ----------------
  initial begin : slave
    bit            burst_active, ar_fire, r_fire, prev_stall;
    logic [AW-1:0] r_addr, prev_addr;
    logic [7:0]    prev_len;
    logic [AW+8-1:0] e;
    int            r_left, beat_no, burst_no;
    burst_active = 0; ar_fire = 0; r_fire = 0; prev_stall = 0;
    r_addr = '0; prev_addr = '0; prev_len = '0; r_left = 0; beat_no = 0; burst_no = 0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        burst_active = 0; ar_fire = 0; r_fire = 0; prev_stall = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        continue;
      end
      if (DONE) done_cnt++;
      if (!BUSY) begin beat_no = 0; burst_no = 0; end
      // A stalled address must still be presented unchanged.
      if (prev_stall) begin
        checks++;
        if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== prev_addr || m_axi_arlen !== prev_len) begin
          errors++;
          $display("FAIL ar_stable: valid=%b addr=%h len=%0d, required valid=1 addr=%h len=%0d",
                   m_axi_arvalid, m_axi_araddr, m_axi_arlen, prev_addr, prev_len);
        end
      end
      // Consequences of the handshakes at the previous posedge.
      if (ar_fire) begin burst_active = 1; r_left = int'(prev_len) + 1; r_addr = prev_addr; end
      if (r_fire) begin
        r_addr += AW'(BPB); r_left--; beat_no++;
        if (r_left == 0) begin burst_active = 0; burst_no++; end
      end
      // Drive the next cycle.
      m_axi_arready = !burst_active && ($urandom_range(0, 3) != 0);
      if (burst_active && $urandom_range(0, 3) != 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = beat_data(r_addr);
        m_axi_rresp  = (beat_no == bad_resp_beat) ? 2'b10 : 2'b00;
        m_axi_rlast  = (r_left == 1) && (burst_no != drop_rlast_burst);
      end else begin
        m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
      end
      ar_fire    = m_axi_arvalid && m_axi_arready;
      r_fire     = m_axi_rvalid && m_axi_rready;
      prev_stall = m_axi_arvalid && !m_axi_arready;
      prev_addr  = m_axi_araddr;
      prev_len   = m_axi_arlen;
      if (ar_fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ar_unexpected: addr=%h len=%0d, required no burst", m_axi_araddr, m_axi_arlen);
        end else begin
          e = exp_q.pop_front();
          if ({m_axi_araddr, m_axi_arlen} !== e) begin
            errors++;
            $display("FAIL ar_burst: addr=%h len=%0d, required addr=%h len=%0d",
                     m_axi_araddr, m_axi_arlen, e[AW+7:8], e[7:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Push the expected burst list for a run, then pulse START for one cycle.
  // Returns in the cycle right after START was sampled.
  task automatic start_run(input logic [AW-1:0] base, input int bytes, input int rep);
    int n, off, bnd, l;
    logic [AW-1:0] a;
    n = bytes / BPB;
    cur_base = base;
    for (int p = 0; p < rep; p++) begin
      off = 0;
      while (off < n) begin
        a   = base + AW'(off * BPB);
        bnd = (4096 - int'(a[11:0])) / BPB;
        l   = 16;
        if (n - off < l) l = n - off;
        if (bnd < l)     l = bnd;
        exp_q.push_back({a, 8'(l - 1)});
        off += l;
      end
    end
    @(negedge ap_clk);
    BASE_ADDR = base; BYTES = 16'(bytes); REPEAT = 16'(rep); START = 1'b1;
    @(negedge ap_clk);
    START = 1'b0;
  endtask

  task automatic wait_done(input int snap, output bit timeout);
    int n;
    n = 0; timeout = 0;
    while (done_cnt == snap) begin
      @(negedge ap_clk);
      n++;
      if (n > 5000) begin timeout = 1; break; end
    end
    repeat (3) @(negedge ap_clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    checks++;
    if ({BUSY, DONE, m_axi_arvalid, m_axi_rready} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: busy/done/arvalid/rready=%b, required 0000",
                         {BUSY, DONE, m_axi_arvalid, m_axi_rready});
    end
    checks++;
    if (ERR_CNT !== 32'd0 || FIRST_ERR_ADDR !== '0) begin
      errors++; $display("FAIL reset_err: err=%0d first=%h, required 0 0", ERR_CNT, FIRST_ERR_ADDR);
    end
    checks++;
    if (m_axi_araddr !== '0 || m_axi_arlen !== 8'd0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_ar: addr=%h len=%0d state=%0d, required 0 0 0",
                         m_axi_araddr, m_axi_arlen, dbg_state);
    end
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
  endtask

  task automatic test_single_burst();
    int snap; bit to;
    snap = done_cnt;
    start_run(32'h1000, 64, 1);
    checks++;
    if (m_axi_arvalid !== 1'b1 || BUSY !== 1'b1) begin
      errors++; $display("FAIL single_t1: arvalid=%b busy=%b, required 1 1", m_axi_arvalid, BUSY);
    end
    checks++;
    if (m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'b01 || m_axi_arprot !== 3'b000) begin
      errors++; $display("FAIL single_const: size=%0d burst=%b prot=%b, required 2 01 000",
                         m_axi_arsize, m_axi_arburst, m_axi_arprot);
    end
    wait_done(snap, to);
    checks++;
    if (to || exp_q.size() != 0 || done_cnt != snap + 1) begin
      errors++; $display("FAIL single_done: timeout=%0d left=%0d dones=%0d, required 0 0 1",
                         to, exp_q.size(), done_cnt - snap);
    end
    checks++;
    if (ERR_CNT !== 32'd0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL single_err: err=%0d busy=%b, required 0 0", ERR_CNT, BUSY);
    end
  endtask

  task automatic test_4k_split();
    int snap; bit to;
    snap = done_cnt;
    start_run(32'h0FF0, 64, 1);
    wait_done(snap, to);
    checks++;
    if (to || exp_q.size() != 0 || done_cnt != snap + 1) begin
      errors++; $display("FAIL split_done: timeout=%0d left=%0d dones=%0d, required 0 0 1",
                         to, exp_q.size(), done_cnt - snap);
    end
    checks++;
    if (ERR_CNT !== 32'd0) begin
      errors++; $display("FAIL split_err: err=%0d, required 0", ERR_CNT);
    end
  endtask

  task automatic test_corrupt_repeat();
    int snap; bit to;
    snap = done_cnt;
    corrupt_off = 'h25;
    start_run(32'h2000, 64, 3);
    // A START while busy must be ignored.
    repeat (3) @(negedge ap_clk);
    START = 1'b1;
    @(negedge ap_clk);
    START = 1'b0;
    wait_done(snap, to);
    checks++;
    if (to || exp_q.size() != 0 || done_cnt != snap + 1) begin
      errors++; $display("FAIL corrupt_done: timeout=%0d left=%0d dones=%0d, required 0 0 1",
                         to, exp_q.size(), done_cnt - snap);
    end
    checks++;
    if (ERR_CNT !== 32'd3 || FIRST_ERR_ADDR !== 32'h2024) begin
      errors++; $display("FAIL corrupt_err: err=%0d first=%h, required 3 00002024", ERR_CNT, FIRST_ERR_ADDR);
    end
    repeat (10) @(negedge ap_clk);
    checks++;
    if (ERR_CNT !== 32'd3 || FIRST_ERR_ADDR !== 32'h2024) begin
      errors++; $display("FAIL corrupt_hold: err=%0d first=%h, required 3 00002024", ERR_CNT, FIRST_ERR_ADDR);
    end
    corrupt_off = -1;
  endtask

  task automatic test_resp_rlast_errors();
    int snap; bit to;
    snap = done_cnt;
    bad_resp_beat = 1; drop_rlast_burst = 1;
    start_run(32'h0FF0, 64, 1);
    checks++;
    if (ERR_CNT !== 32'd0) begin
      errors++; $display("FAIL resp_cleared: err=%0d, required 0", ERR_CNT);
    end
    wait_done(snap, to);
    checks++;
    if (to || exp_q.size() != 0 || done_cnt != snap + 1) begin
      errors++; $display("FAIL resp_done: timeout=%0d left=%0d dones=%0d, required 0 0 1",
                         to, exp_q.size(), done_cnt - snap);
    end
    checks++;
    if (ERR_CNT !== 32'd2 || FIRST_ERR_ADDR !== 32'h0FF4) begin
      errors++; $display("FAIL resp_err: err=%0d first=%h, required 2 00000ff4", ERR_CNT, FIRST_ERR_ADDR);
    end
    bad_resp_beat = -1; drop_rlast_burst = -1;
  endtask

  task automatic test_degenerate(input int bytes, input int rep);
    start_run(32'h3000, bytes, rep);
    checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b0 || m_axi_arvalid !== 1'b0) begin
      errors++; $display("FAIL degen_t1 (%0d,%0d): busy=%b done=%b arvalid=%b, required 1 0 0",
                         bytes, rep, BUSY, DONE, m_axi_arvalid);
    end
    @(negedge ap_clk);
    checks++;
    if (BUSY !== 1'b1 || DONE !== 1'b1 || m_axi_arvalid !== 1'b0) begin
      errors++; $display("FAIL degen_t2 (%0d,%0d): busy=%b done=%b arvalid=%b, required 1 1 0",
                         bytes, rep, BUSY, DONE, m_axi_arvalid);
    end
    @(negedge ap_clk);
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++; $display("FAIL degen_t3 (%0d,%0d): busy=%b done=%b, required 0 0", bytes, rep, BUSY, DONE);
    end
    repeat (2) @(negedge ap_clk);
  endtask

  task automatic test_reset_mid_burst();
    int n, snap; bit to;
    start_run(32'h4000, 1024, 2);
    n = 0;
    while (m_axi_rready !== 1'b1 && n < 200) begin @(negedge ap_clk); n++; end
    checks++;
    if (n >= 200) begin
      errors++; $display("FAIL rst_reach_data: rready=%b, required 1 within 200 cycles", m_axi_rready);
    end
    repeat (3) @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({BUSY, DONE, m_axi_arvalid, m_axi_rready} !== 4'b0000 || m_axi_araddr !== '0 ||
        m_axi_arlen !== 8'd0 || dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL rst_mid: busy/done/arvalid/rready=%b addr=%h len=%0d, required 0000 0 0",
                         {BUSY, DONE, m_axi_arvalid, m_axi_rready}, m_axi_araddr, m_axi_arlen);
    end
    exp_q.delete();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    snap = done_cnt;
    start_run(32'h5000, 128, 1);
    wait_done(snap, to);
    checks++;
    if (to || exp_q.size() != 0 || done_cnt != snap + 1 || ERR_CNT !== 32'd0) begin
      errors++; $display("FAIL rst_recover: timeout=%0d left=%0d dones=%0d err=%0d, required 0 0 1 0",
                         to, exp_q.size(), done_cnt - snap, ERR_CNT);
    end
  endtask

  task automatic test_back_to_back();
    int snap; bit to;
    snap = done_cnt;
    start_run(32'h6FF8, 200, 2);
    wait_done(snap, to);
    start_run(32'h7000, 32, 1);
    wait_done(snap + 1, to);
    checks++;
    if (to || exp_q.size() != 0 || done_cnt != snap + 2 || ERR_CNT !== 32'd0) begin
      errors++; $display("FAIL b2b: timeout=%0d left=%0d dones=%0d err=%0d, required 0 0 2 0",
                         to, exp_q.size(), done_cnt - snap, ERR_CNT);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    BASE_ADDR = '0; BYTES = '0; REPEAT = '0; START = 1'b0;
    test_reset();
    test_single_burst();
    test_4k_split();
    test_corrupt_repeat();
    test_resp_rlast_errors();
    test_degenerate(64, 0);
    test_degenerate(3, 1);
    test_reset_mid_burst();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
